// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster generator.
// Holds the colour-bar palette, pixel-source mode encodings and a width helper.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_EXT   = 2'd0,
        MODE_BAR   = 2'd1,
        MODE_GRID  = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    // RGB565 colour bars in display order.
    localparam logic [15:0] PALETTE [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    // Bit width needed to hold 0..n-1; never less than 1.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Built-in test pattern source: colour bars, grid or a solid colour.
// Ports: clk/rst, active + pix_x/pix_y of the stage-0 pixel, mode, solid_rgb;
// pat_rgb is the registered colour, aligned with external data in stage 1.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ADDR  = 800,
    parameter int BAR_NUM = 4,
    parameter int RGB_W   = 16,
    parameter int XW      = 10,
    parameter int YW      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    input  logic [1:0]       mode,
    input  logic [XW-1:0]    pix_x,
    input  logic [YW-1:0]    pix_y,
    input  logic [RGB_W-1:0] solid_rgb,
    output logic [RGB_W-1:0] pat_rgb
);

    localparam int BAR_W = H_ADDR / BAR_NUM;
    localparam int BW    = width_of(BAR_W);

    logic [BW-1:0]    bar_cnt;
    logic [BW-1:0]    cur_cnt;
    logic [2:0]       bar_idx;
    logic [2:0]       cur_idx;
    logic             line_start;
    logic [RGB_W-1:0] nxt_rgb;

    // Column 0 restarts the bar walk, so the counter needs no line clear.
    always_comb begin
        line_start = (pix_x == '0);
        cur_cnt    = line_start ? '0 : bar_cnt;
        cur_idx    = line_start ? '0 : bar_idx;
        nxt_rgb    = '0;
        case (mode)
            MODE_BAR:   nxt_rgb = RGB_W'(PALETTE[cur_idx]);
            MODE_GRID: begin
                if ((32'(pix_x) & 32'h1F) == 32'd0 ||
                    (32'(pix_y) & 32'h1F) == 32'd0)
                    nxt_rgb = RGB_W'(16'hFFFF);
            end
            MODE_SOLID: nxt_rgb = solid_rgb;
            default:    nxt_rgb = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bar_cnt <= '0;
            bar_idx <= '0;
            pat_rgb <= '0;
        end else begin
            pat_rgb <= active ? nxt_rgb : '0;
            if (active) begin
                if (cur_cnt == BW'(BAR_W - 1)) begin
                    bar_cnt <= '0;
                    bar_idx <= cur_idx + 3'd1;
                end else begin
                    bar_cnt <= cur_cnt + 1'b1;
                    bar_idx <= cur_idx;
                end
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator with pattern or external pixel source.
// Ports: sclk/s_rst, mode, solid_rgb, pix_req/pix_x/pix_y/pix_data/pix_valid
// to the pixel source; vga_hsync/vsync/de/rgb, frame_start, underflow out.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_TOTAL  = 1056,
    parameter int H_ADDR   = 800,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_TOTAL  = 628,
    parameter int V_ADDR   = 600,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int SYNC_POL = 1,
    parameter int RGB_W    = 16,
    parameter int BAR_NUM  = 4
) (
    input  logic                          sclk,
    input  logic                          s_rst,
    input  logic [1:0]                    mode,
    input  logic [RGB_W-1:0]              solid_rgb,
    output logic                          pix_req,
    output logic [width_of(H_ADDR)-1:0]   pix_x,
    output logic [width_of(V_ADDR)-1:0]   pix_y,
    input  logic [RGB_W-1:0]              pix_data,
    input  logic                          pix_valid,
    output logic                          vga_hsync,
    output logic                          vga_vsync,
    output logic                          vga_de,
    output logic [RGB_W-1:0]              vga_rgb,
    output logic                          frame_start,
    output logic                          underflow
);

    localparam int HW      = width_of(H_TOTAL);
    localparam int VW      = width_of(V_TOTAL);
    localparam int XW      = width_of(H_ADDR);
    localparam int YW      = width_of(V_ADDR);
    localparam int H_START = H_SYNC + H_BP;
    localparam int H_END   = H_START + H_ADDR;
    localparam int V_START = V_SYNC + V_BP;
    localparam int V_END   = V_START + V_ADDR;
    localparam logic INV   = (SYNC_POL == 0);

    logic [HW-1:0]    cnt_h;
    logic [VW-1:0]    cnt_v;
    mode_e            mode_r;
    logic [31:0]      h32;
    logic [31:0]      v32;
    logic             active;
    logic             raw_hs;
    logic             raw_vs;
    logic             first;
    logic [RGB_W-1:0] pat_rgb;
    logic [RGB_W-1:0] ext_rgb;
    logic             s1_act;
    logic             s1_ext;
    logic             s1_hs;
    logic             s1_vs;
    logic             s1_fs;

    // Stage 0: compare in 32 bits so an end offset equal to the total
    // cannot alias to zero in a narrow counter.
    always_comb begin
        h32     = 32'(cnt_h);
        v32     = 32'(cnt_v);
        active  = (h32 >= H_START) && (h32 < H_END) &&
                  (v32 >= V_START) && (v32 < V_END);
        raw_hs  = (h32 < H_SYNC);
        raw_vs  = (v32 < V_SYNC);
        first   = (cnt_h == '0) && (cnt_v == '0);
        pix_req = active && (mode_r == MODE_EXT);
        pix_x   = active ? XW'(h32 - 32'(H_START)) : '0;
        pix_y   = active ? YW'(v32 - 32'(V_START)) : '0;
        ext_rgb = pix_valid ? pix_data : '0;
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            cnt_h  <= '0;
            cnt_v  <= '0;
            mode_r <= MODE_EXT;
        end else begin
            if (first)
                mode_r <= mode_e'(mode);
            if (h32 == H_TOTAL - 1) begin
                cnt_h <= '0;
                if (v32 == V_TOTAL - 1)
                    cnt_v <= '0;
                else
                    cnt_v <= cnt_v + 1'b1;
            end else begin
                cnt_h <= cnt_h + 1'b1;
            end
        end
    end

    vga_pattern_gen #(
        .H_ADDR  (H_ADDR),
        .BAR_NUM (BAR_NUM),
        .RGB_W   (RGB_W),
        .XW      (XW),
        .YW      (YW)
    ) u_pattern (
        .clk       (sclk),
        .rst       (s_rst),
        .active    (active),
        .mode      (mode_r),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .solid_rgb (solid_rgb),
        .pat_rgb   (pat_rgb)
    );

    // Stage 1: timing flags follow the request while the source responds.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            s1_act <= 1'b0;
            s1_ext <= 1'b0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_fs  <= 1'b0;
        end else begin
            s1_act <= active;
            s1_ext <= pix_req;
            s1_hs  <= raw_hs;
            s1_vs  <= raw_vs;
            s1_fs  <= first;
        end
    end

    // Stage 2: registered outputs.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            vga_hsync   <= INV;
            vga_vsync   <= INV;
            vga_de      <= 1'b0;
            vga_rgb     <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            vga_hsync   <= s1_hs ^ INV;
            vga_vsync   <= s1_vs ^ INV;
            vga_de      <= s1_act;
            vga_rgb     <= !s1_act ? '0 : (s1_ext ? ext_rgb : pat_rgb);
            frame_start <= s1_fs;
            underflow   <= s1_ext && !pix_valid;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 20x10 raster (8x4 active).
// Two instances share inputs: active-high and active-low sync polarity.
module tb_vga_timing_gen;

    localparam logic [20:0] NMASK = {2'b11, 19'd0};
    localparam logic [15:0] BAR_TAB [4] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0
    };

    logic        sclk = 1'b0;
    logic        s_rst = 1'b1;
    logic [1:0]  mode = 2'd1;
    logic [15:0] solid_rgb = 16'h1234;
    logic [15:0] pix_data = 16'h0;
    logic        pix_valid = 1'b1;
    logic        drop_en = 1'b0;

    logic        pix_req, n_pix_req;
    logic [2:0]  pix_x, n_pix_x;
    logic [1:0]  pix_y, n_pix_y;
    logic        hs, vs, de, fs, uf;
    logic        n_hs, n_vs, n_de, n_fs, n_uf;
    logic [15:0] rgb, n_rgb;
    logic [20:0] vec, nvec;

    int total = 0;
    int bad = 0;

    assign vec  = {hs, vs, de, fs, uf, rgb};
    assign nvec = {n_hs, n_vs, n_de, n_fs, n_uf, n_rgb};

    always #5 sclk = ~sclk;

    vga_timing_gen #(
        .H_TOTAL(20), .H_ADDR(8), .H_SYNC(2), .H_BP(3),
        .V_TOTAL(10), .V_ADDR(4), .V_SYNC(1), .V_BP(2),
        .SYNC_POL(1), .RGB_W(16), .BAR_NUM(4)
    ) dut (
        .sclk(sclk), .s_rst(s_rst), .mode(mode), .solid_rgb(solid_rgb),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
        .pix_data(pix_data), .pix_valid(pix_valid),
        .vga_hsync(hs), .vga_vsync(vs), .vga_de(de), .vga_rgb(rgb),
        .frame_start(fs), .underflow(uf)
    );

    vga_timing_gen #(
        .H_TOTAL(20), .H_ADDR(8), .H_SYNC(2), .H_BP(3),
        .V_TOTAL(10), .V_ADDR(4), .V_SYNC(1), .V_BP(2),
        .SYNC_POL(0), .RGB_W(16), .BAR_NUM(4)
    ) dut_n (
        .sclk(sclk), .s_rst(s_rst), .mode(mode), .solid_rgb(solid_rgb),
        .pix_req(n_pix_req), .pix_x(n_pix_x), .pix_y(n_pix_y),
        .pix_data(pix_data), .pix_valid(pix_valid),
        .vga_hsync(n_hs), .vga_vsync(n_vs), .vga_de(n_de), .vga_rgb(n_rgb),
        .frame_start(n_fs), .underflow(n_uf)
    );

    // FIFO model: 1-cycle latency, data = y*8 + x, optional 3-pixel drop.
    always @(posedge sclk) begin
        pix_data  <= 16'({pix_y, pix_x});
        pix_valid <= !(drop_en && pix_req && pix_y == 2'd1 &&
                       pix_x >= 3'd3 && pix_x <= 3'd5);
    end

    // Expected {hs, vs, de, fs, uf, rgb} at output position t of a frame.
    function automatic logic [20:0] exp_vec(int kind, int t, bit drop);
        int h = t % 20;
        int v = t / 20;
        int x = h - 5;
        int y = v - 3;
        logic e_de = (h >= 5 && h < 13 && v >= 3 && v < 7);
        logic [15:0] c = 16'h0;
        logic u = 1'b0;
        if (e_de) begin
            case (kind)
                0: begin
                    c = 16'(y * 8 + x);
                    if (drop && y == 1 && x >= 3 && x <= 5) begin
                        c = 16'h0;
                        u = 1'b1;
                    end
                end
                1: c = BAR_TAB[x / 2];
                2: c = (x == 0 || y == 0) ? 16'hFFFF : 16'h0000;
                default: c = 16'h0;
            endcase
        end
        return {h < 2, v < 1, e_de, t == 0, u, c};
    endfunction

    task automatic step();
        @(posedge sclk);
        @(negedge sclk);
    endtask

    task automatic test_reset();
        s_rst = 1'b1;
        mode = 2'd1;
        repeat (3) step();
        total++;
        if (vec !== 21'd0) begin
            bad++; $display("FAIL reset_vec got=%h exp=%h", vec, 21'd0);
        end
        total++;
        if (nvec !== NMASK) begin
            bad++; $display("FAIL reset_vec_n got=%h exp=%h", nvec, NMASK);
        end
        total++;
        if (pix_req !== 1'b0) begin
            bad++; $display("FAIL reset_req got=%b exp=0", pix_req);
        end
        s_rst = 1'b0;
        step();
        total++;
        if (fs !== 1'b0) begin
            bad++; $display("FAIL fs_early got=%b exp=0", fs);
        end
        step();
        total++;
        if (fs !== 1'b1) begin
            bad++; $display("FAIL fs_latency got=%b exp=1", fs);
        end
    endtask

    task automatic test_bars();
        int nh = 0, nv = 0, nd = 0, nr = 0;
        logic [20:0] e;
        for (int t = 0; t < 200; t++) begin
            e = exp_vec(1, t, 1'b0);
            total++;
            if (vec !== e) begin
                bad++; $display("FAIL bars t=%0d got=%h exp=%h", t, vec, e);
            end
            total++;
            if (nvec !== (e ^ NMASK)) begin
                bad++;
                $display("FAIL bars_n t=%0d got=%h exp=%h", t, nvec, e ^ NMASK);
            end
            nh += int'(hs); nv += int'(vs); nd += int'(de); nr += int'(pix_req);
            step();
        end
        total++;
        if (nh != 20) begin bad++; $display("FAIL hs_count got=%0d exp=20", nh); end
        total++;
        if (nv != 20) begin bad++; $display("FAIL vs_count got=%0d exp=20", nv); end
        total++;
        if (nd != 32) begin bad++; $display("FAIL de_count got=%0d exp=32", nd); end
        total++;
        if (nr != 0) begin bad++; $display("FAIL req_in_bars got=%0d exp=0", nr); end
    endtask

    task automatic test_mode_change();
        int nfs;
        logic [20:0] e;
        for (int f = 0; f < 2; f++) begin
            nfs = 0;
            for (int t = 0; t < 200; t++) begin
                if (t == 100) mode = (f == 0) ? 2'd2 : 2'd0;
                e = exp_vec(f == 0 ? 1 : 2, t, 1'b0);
                total++;
                if (vec !== e) begin
                    bad++;
                    $display("FAIL mode_chg f=%0d t=%0d got=%h exp=%h", f, t, vec, e);
                end
                nfs += int'(fs);
                step();
            end
            total++;
            if (nfs != 1) begin
                bad++; $display("FAIL fs_per_frame f=%0d got=%0d exp=1", f, nfs);
            end
        end
    endtask

    task automatic test_ext_fifo();
        int nr = 0, nu = 0, nd = 0;
        logic [20:0] e;
        for (int t = 0; t < 200; t++) begin
            e = exp_vec(0, t, 1'b0);
            total++;
            if (vec !== e) begin
                bad++; $display("FAIL ext t=%0d got=%h exp=%h", t, vec, e);
            end
            nr += int'(pix_req); nu += int'(uf); nd += int'(de);
            step();
        end
        total++;
        if (nr != 32) begin bad++; $display("FAIL ext_req_count got=%0d exp=32", nr); end
        total++;
        if (nu != 0) begin bad++; $display("FAIL ext_underflow got=%0d exp=0", nu); end
        total++;
        if (nd != 32) begin bad++; $display("FAIL ext_de_count got=%0d exp=32", nd); end
    endtask

    task automatic test_underflow();
        int nu = 0;
        logic [20:0] e;
        drop_en = 1'b1;
        for (int t = 0; t < 200; t++) begin
            if (t == 100) mode = 2'd1;
            e = exp_vec(0, t, 1'b1);
            total++;
            if (vec !== e) begin
                bad++; $display("FAIL underflow t=%0d got=%h exp=%h", t, vec, e);
            end
            nu += int'(uf);
            step();
        end
        drop_en = 1'b0;
        total++;
        if (nu != 3) begin bad++; $display("FAIL uf_count got=%0d exp=3", nu); end
    endtask

    task automatic test_reset_mid();
        int nd = 0;
        logic [20:0] e;
        for (int t = 0; t <= 85; t++) begin
            e = exp_vec(1, t, 1'b0);
            total++;
            if (vec !== e) begin
                bad++; $display("FAIL pre_rst t=%0d got=%h exp=%h", t, vec, e);
            end
            if (t < 85) step();
        end
        s_rst = 1'b1;
        step();
        total++;
        if (vec !== 21'd0) begin
            bad++; $display("FAIL mid_rst_vec got=%h exp=%h", vec, 21'd0);
        end
        total++;
        if (nvec !== NMASK) begin
            bad++; $display("FAIL mid_rst_vec_n got=%h exp=%h", nvec, NMASK);
        end
        total++;
        if (pix_req !== 1'b0) begin
            bad++; $display("FAIL mid_rst_req got=%b exp=0", pix_req);
        end
        s_rst = 1'b0;
        step();
        total++;
        if (vec !== 21'd0) begin
            bad++; $display("FAIL mid_rst_gap got=%h exp=%h", vec, 21'd0);
        end
        step();
        for (int t = 0; t < 200; t++) begin
            e = exp_vec(1, t, 1'b0);
            total++;
            if (vec !== e) begin
                bad++; $display("FAIL post_rst t=%0d got=%h exp=%h", t, vec, e);
            end
            nd += int'(de);
            step();
        end
        total++;
        if (nd != 32) begin bad++; $display("FAIL post_rst_de got=%0d exp=32", nd); end
    endtask

    initial begin
        test_reset();
        test_bars();
        test_mode_change();
        test_ext_fifo();
        test_underflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster generator, successor to the fixed 800x600 colour-bar driver. It produces sync, data-enable and RGB for any timing set given by parameters, with selectable sync polarity. Pixels come either from a built-in pattern (colour bars, grid, solid) or from an external pixel stream, typically the SDRAM read FIFO, through a 1-cycle-latency read request. It sits between the frame-buffer read path and the VGA DAC/pins.

## Interface
- H_TOTAL, 1056: pixels per line, including blanking
- H_ADDR, 800: active pixels per line
- H_SYNC, 128: hsync width in pixels
- H_BP, 88: horizontal back porch
- V_TOTAL, 628: lines per frame
- V_ADDR, 600: active lines
- V_SYNC, 4: vsync width in lines
- V_BP, 23: vertical back porch
- SYNC_POL, 1: 1 = syncs active-high, 0 = active-low
- RGB_W, 16: pixel width (RGB565 at 16)
- BAR_NUM, 4: number of colour bars, 1..8; H_ADDR must be divisible by BAR_NUM

Ports:
- sclk  in  1  pixel clock
- s_rst  in  1  synchronous, active-high reset
- mode  in  2  0 external, 1 colour bars, 2 grid, 3 solid
- solid_rgb  in  RGB_W  colour used in mode 3
- pix_req  out  1  read request to the pixel source
- pix_x  out  clog2(H_ADDR)  active column of the current request
- pix_y  out  clog2(V_ADDR)  active row of the current request
- pix_data  in  RGB_W  external pixel, valid 1 cycle after pix_req
- pix_valid  in  1  qualifies pix_data (low = FIFO empty)
- vga_hsync  out  1  horizontal sync, polarity per SYNC_POL
- vga_vsync  out  1  vertical sync, polarity per SYNC_POL
- vga_de  out  1  active video
- vga_rgb  out  RGB_W  pixel; 0 whenever vga_de is low
- frame_start  out  1  1-cycle pulse on the first output cycle of a frame (h=0, v=0)
- underflow  out  1  1-cycle pulse on a consumed pixel while pix_valid is low

## Operation
- cnt_h counts 0..H_TOTAL-1 and wraps to 0. cnt_v increments when cnt_h wraps, counts 0..V_TOTAL-1, and wraps to 0.
- Raw hsync = cnt_h < H_SYNC. Raw vsync = cnt_v < V_SYNC. Outputs are XOR-adjusted: they are inverted when SYNC_POL=0.
- Active region:
  - H_SYNC+H_BP <= cnt_h < H_SYNC+H_BP+H_ADDR
  - V_SYNC+V_BP <= cnt_v < V_SYNC+V_BP+V_ADDR
- pix_x and pix_y are the counter values minus their offsets. Both are 0 outside the active region.
- pix_req = active, in mode 0 only. In pattern modes it stays 0.
- The mode register samples `mode` only when cnt_h=0 and cnt_v=0. Mode changes mid-frame take effect at the next frame.
- Pattern generation:
  - Bars: bar index advances every H_ADDR/BAR_NUM pixels, using a counter with no divider. Palette in index order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000 (RGB565, zero-extended or truncated to RGB_W).
  - Grid: FFFF when pix_x[4:0]==0 or pix_y[4:0]==0, else 0000.
  - Solid: solid_rgb.
- External mode: a consumed pixel with pix_valid=1 outputs pix_data. With pix_valid=0 it outputs 0 and pulses underflow. The stream does not re-synchronise; the source is responsible.

## Timing
- Stage 0: counters, pix_req, pix_x, pix_y.
- Stage 1: pix_data and pix_valid arrive; pattern colour is computed.
- Stage 2: all vga_* outputs, frame_start and underflow are registered.
- Sync, de, frame_start and rgb therefore lag the counters by exactly 2 cycles and stay mutually aligned.
- Reset values (s_rst high at a sclk edge):
  - Counters 0, mode register 0.
  - pix_req 0, vga_de 0, vga_rgb 0, frame_start 0, underflow 0.
  - vga_hsync and vga_vsync at their inactive level (~SYNC_POL).
- First frame_start occurs 2 cycles after reset is released.
- Reset mid-frame aborts the frame immediately. The pipeline is flushed, with no partial pixels emitted.
- Last pixel of a line (pix_x = H_ADDR-1) is followed by pix_req low on the next cycle. No request is ever issued during blanking.
- Counter widths are clog2(H_TOTAL) and clog2(V_TOTAL). Offsets are computed at elaboration.

## Structure
- Package vga_pkg holds the 8-entry RGB565 palette constant, mode encodings (MODE_EXT, MODE_BAR, MODE_GRID, MODE_SOLID), and a clog2-safe width helper.
- One sub-module, vga_pattern_gen: takes mode, pix_x, pix_y and solid_rgb and returns the pattern colour for stage 1. It owns the bar counter.
- Counters, pipeline and output muxing stay in the top module.

## Test plan
- Small timing (H 20/8/2/3, V 10/4/1/2), mode 1, BAR_NUM 4:
  - hsync is high for 2 of every 20 cycles; vsync is high for 20 cycles per 200.
  - vga_de is high 8 cycles per active line, on 4 lines.
  - Bars run 2 pixels each: FFFF, FFE0, 07FF, 07E0.
- SYNC_POL=0, same timing: syncs are inverted; de and rgb are unchanged; reset leaves both syncs at 1.
- Mode 0 with a FIFO model (1-cycle latency, data = pix_y*8 + pix_x): output row 2 reads 16..23 in order, aligned with vga_de; pix_req count per frame = 32.
- Mode 0, pix_valid forced low for 3 requests mid-line: those 3 vga_rgb values are 0, underflow pulses 3 times, and neighbouring pixels are unaffected.
- Change mode 1→2 mid-frame: the current frame stays bars and the next frame is a grid; frame_start pulses once per 200 cycles.
- Assert s_rst for 1 cycle mid-line: all outputs take reset values the next cycle, and the frame restarts with frame_start 2 cycles after release.
